char_move_ctrl: RTL and testbench

CHAR_MOVE_CTRL -- requirements
Module: char_move_ctrl

---
 rtl/char_move_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_char_move_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_move_ctrl.sv
// -----------------------------------------------------------------------------
// char_move_ctrl
//
// Tile-based overworld character movement controller. The character sits on a
// 16x16 pixel tile grid. A direction key first turns the character to face
// that way (TURN, 4 frames). Pressing the key it already faces takes a full
// 16 px step (WALK), or plays a bump animation (BUMP, 16 frames) when the
// destination tile is blocked or lies past the map edge. All motion advances
// only on frame_tick; Reset acts on any Clk edge and wins over frame_tick.
//
// Optional feature (macro CHAR_RUN_EN):
//   defined   -> run_btn held when a step starts makes it a 2 px/frame run step
//   undefined -> run_btn ignored, charIsRunning is always 0, 1 px/frame steps
//
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   frame_tick             one-Clk pulse per video frame
//   move_en                overworld active; gates starting new actions
//   keycode[7:0]           0x1A up, 0x16 down, 0x04 left, 0x07 right
//   run_btn                run request, sampled at step start
//   blocked                destination tile not walkable (from target_x/y)
//   target_x/target_y      tile adjacent in the key direction (clamped)
//   charxcurrpos/charycurrpos  character position, pixels
//   direction[1:0]         facing: 00 down, 01 up, 10 left, 11 right
//   charIsMoving           high while walking
//   charIsRunning          high while the current step is a run step
//   charMoveFrame[1:0]     animation frame
//   atTile                 high when idle on a tile boundary
// -----------------------------------------------------------------------------
module char_move_ctrl #(
  parameter logic [9:0] START_X = 10'd208,
  parameter logic [9:0] START_Y = 10'd224,
  parameter logic [9:0] MAX_X   = 10'd624,
  parameter logic [9:0] MAX_Y   = 10'd464
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       move_en,
  input  logic [7:0] keycode,
  input  logic       run_btn,
  input  logic       blocked,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic [9:0] charxcurrpos,
  output logic [9:0] charycurrpos,
  output logic [1:0] direction,
  output logic       charIsMoving,
  output logic       charIsRunning,
  output logic [1:0] charMoveFrame,
  output logic       atTile
);

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [9:0] TILE      = 10'd16;

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_WALK, S_BUMP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [9:0]        pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic [1:0]        dir_q, dir_nxt;
  logic              run_q, run_nxt, run_sel;
  logic              key_vld;
  logic [1:0]        key_dir;
  logic signed [9:0] step_mag, step_delta;
  logic [4:0]        walk_sum;

  // True when stepping from (x,y) in direction d would leave the map.
  function automatic logic at_edge(input logic [1:0] d, input logic [9:0] x,
                                   input logic [9:0] y);
    logic edge_hit;
    edge_hit = 1'b0;
    case (d)
      DIR_DOWN:  edge_hit = (y >= MAX_Y);
      DIR_UP:    edge_hit = (y == 10'd0);
      DIR_LEFT:  edge_hit = (x == 10'd0);
      DIR_RIGHT: edge_hit = (x >= MAX_X);
      default:   edge_hit = 1'b0;
    endcase
    return edge_hit;
  endfunction

`ifdef CHAR_RUN_EN
  assign run_sel = run_btn;
`else
  logic run_btn_unused;
  assign run_btn_unused = run_btn;
  assign run_sel        = 1'b0;
`endif

  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_DOWN;
    case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      8'h07:   key_dir = DIR_RIGHT;
      default: key_vld = 1'b0;
    endcase
  end

  // Neighbour tile in the key direction; clamped to the current tile at an edge.
  always_comb begin
    target_x = pos_x;
    target_y = pos_y;
    if (key_vld && !at_edge(key_dir, pos_x, pos_y)) begin
      case (key_dir)
        DIR_DOWN:  target_y = pos_y + TILE;
        DIR_UP:    target_y = pos_y - TILE;
        DIR_LEFT:  target_x = pos_x - TILE;
        DIR_RIGHT: target_x = pos_x + TILE;
        default:   target_x = pos_x;
      endcase
    end
  end

  // Signed per-frame displacement along the facing axis.
  always_comb begin
    step_mag   = run_q ? 10'sd2 : 10'sd1;
    step_delta = ((dir_q == DIR_UP) || (dir_q == DIR_LEFT)) ? -step_mag : step_mag;
    // Bit 4 of the sum marks the 16 px step as complete; bits 3:0 then wrap to 0.
    walk_sum   = {1'b0, cnt} + (run_q ? 5'd2 : 5'd1);
  end

  // Next-state logic: everything holds unless frame_tick is high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    run_nxt   = run_q;
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    if (frame_tick) begin
      case (state)
        S_IDLE: begin
          if (move_en && key_vld) begin
            cnt_nxt = 4'd0;
            if (key_dir != dir_q) begin
              dir_nxt   = key_dir;
              state_nxt = S_TURN;
            end else if (blocked || at_edge(dir_q, pos_x, pos_y)) begin
              state_nxt = S_BUMP;
            end else begin
              run_nxt   = run_sel;
              state_nxt = S_WALK;
            end
          end
        end
        S_TURN: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd3) begin
            cnt_nxt   = 4'd0;
            state_nxt = S_IDLE;
          end
        end
        S_WALK: begin
          cnt_nxt = walk_sum[3:0];
          if (dir_q[1]) pos_x_nxt = pos_x + $unsigned(step_delta);
          else          pos_y_nxt = pos_y + $unsigned(step_delta);
          if (walk_sum[4]) state_nxt = S_IDLE;
        end
        S_BUMP: begin
          // Counter wraps 15 -> 0 on the last bump frame.
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd15) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      dir_q <= DIR_DOWN;
      run_q <= 1'b0;
      pos_x <= START_X;
      pos_y <= START_Y;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
      run_q <= run_nxt;
      pos_x <= pos_x_nxt;
      pos_y <= pos_y_nxt;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    charxcurrpos  = pos_x;
    charycurrpos  = pos_y;
    direction     = dir_q;
    charIsMoving  = 1'b0;
    charIsRunning = 1'b0;
    charMoveFrame = 2'b00;
    atTile        = 1'b0;
    case (state)
      S_IDLE: atTile = 1'b1;
      S_TURN: charMoveFrame = 2'b01;
      S_WALK: begin
        charIsMoving  = 1'b1;
        charIsRunning = run_q;
        charMoveFrame = cnt[3:2];
      end
      S_BUMP: charMoveFrame = cnt[3:2];
      default: atTile = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_char_move_ctrl.sv
module tb_char_move_ctrl;

`ifdef CHAR_RUN_EN
  localparam bit RUN_EN = 1'b1;
`else
  localparam bit RUN_EN = 1'b0;
`endif
  localparam int SX = 208, SY = 224, MX = 624, MY = 464;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       move_en = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       run_btn = 1'b0;
  logic       blocked = 1'b0;
  logic [9:0] target_x, target_y, charxcurrpos, charycurrpos;
  logic [1:0] direction, charMoveFrame;
  logic       charIsMoving, charIsRunning, atTile;

  always #5 clk = ~clk;

  char_move_ctrl dut (
    .Clk(clk), .Reset(Reset), .frame_tick(frame_tick), .move_en(move_en),
    .keycode(keycode), .run_btn(run_btn), .blocked(blocked),
    .target_x(target_x), .target_y(target_y),
    .charxcurrpos(charxcurrpos), .charycurrpos(charycurrpos),
    .direction(direction), .charIsMoving(charIsMoving),
    .charIsRunning(charIsRunning), .charMoveFrame(charMoveFrame), .atTile(atTile)
  );

  typedef struct packed {
    logic [9:0] x, y, tx, ty;
    logic [1:0] dir, frm;
    logic       mov, run, at;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 turning, 2 walking, 3 bumping.
  int m_mode = 0, m_el = 0, m_x = SX, m_y = SY, m_ox = SX, m_oy = SY, m_dir = 0;
  bit m_run = 0;

  function automatic int key_dir(input logic [7:0] kc);
    case (kc)
      8'h1A:   return 1;
      8'h16:   return 0;
      8'h04:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ddx(input int d);
    return (d == 3) ? 1 : ((d == 2) ? -1 : 0);
  endfunction

  function automatic int ddy(input int d);
    return (d == 0) ? 1 : ((d == 1) ? -1 : 0);
  endfunction

  function automatic bit off_edge(input int d, input int x, input int y);
    return (d == 0 && y == MY) || (d == 1 && y == 0) || (d == 2 && x == 0) || (d == 3 && x == MX);
  endfunction

  task automatic model_step(input bit ft, input bit rst, input logic [7:0] kc,
                            input bit me, input bit rb, input bit bl);
    int kd;
    int spd;
    int mv;
    kd = key_dir(kc);
    if (rst) begin
      m_mode = 0; m_el = 0; m_x = SX; m_y = SY; m_dir = 0; m_run = 0;
    end else if (ft) begin
      case (m_mode)
        0: if (me && kd >= 0) begin
          m_el = 0;
          if (kd != m_dir) begin
            m_dir = kd; m_mode = 1;
          end else if (bl || off_edge(m_dir, m_x, m_y)) begin
            m_mode = 3;
          end else begin
            m_mode = 2; m_run = RUN_EN && rb; m_ox = m_x; m_oy = m_y;
          end
        end
        1: begin
          m_el++;
          if (m_el == 4) m_mode = 0;
        end
        2: begin
          m_el++;
          spd = m_run ? 2 : 1;
          mv  = m_el * spd;
          m_x = m_ox + ddx(m_dir) * mv;
          m_y = m_oy + ddy(m_dir) * mv;
          if (mv == 16) m_mode = 0;
        end
        default: begin
          m_el++;
          if (m_el == 16) m_mode = 0;
        end
      endcase
    end
  endtask

  function automatic exp_t model_out(input logic [7:0] kc);
    exp_t e;
    int kd;
    int tx;
    int ty;
    int spd;
    kd  = key_dir(kc);
    tx  = m_x;
    ty  = m_y;
    spd = m_run ? 2 : 1;
    if (kd >= 0 && !off_edge(kd, m_x, m_y)) begin
      tx = m_x + 16 * ddx(kd);
      ty = m_y + 16 * ddy(kd);
    end
    e.x   = 10'(m_x);
    e.y   = 10'(m_y);
    e.tx  = 10'(tx);
    e.ty  = 10'(ty);
    e.dir = 2'(m_dir);
    e.mov = (m_mode == 2);
    e.run = (m_mode == 2) && m_run;
    e.at  = (m_mode == 0);
    case (m_mode)
      0:       e.frm = 2'd0;
      1:       e.frm = 2'd1;
      2:       e.frm = 2'(((m_el * spd) / 4) % 4);
      default: e.frm = 2'((m_el / 4) % 4);
    endcase
    return e;
  endfunction

  // Drive one clock's worth of inputs and queue the expected post-edge outputs.
  task automatic tick(input bit ft, input bit rst, input logic [7:0] kc,
                      input bit me, input bit rb, input bit bl);
    @(negedge clk);
    frame_tick = ft; Reset = rst; keycode = kc; move_en = me; run_btn = rb; blocked = bl;
    model_step(ft, rst, kc, me, rb, bl);
    exp_q.push_back(model_out(kc));
  endtask

  // n frame ticks with fixed inputs; a non-tick clock is slipped in every third.
  task automatic step_n(input int n, input logic [7:0] kc, input bit rb, input bit bl);
    for (int i = 0; i < n; i++) begin
      if (i % 3 == 2) tick(1'b0, 1'b0, kc, 1'b1, rb, bl);
      tick(1'b1, 1'b0, kc, 1'b1, rb, bl);
    end
  endtask

  // Quiet clock so several absolute checks can be made after it.
  task automatic settle(input logic [7:0] kc);
    tick(1'b0, 1'b0, kc, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Scoreboard monitor: compares every clock that has a queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (charxcurrpos !== e.x || charycurrpos !== e.y || target_x !== e.tx ||
            target_y !== e.ty || direction !== e.dir || charMoveFrame !== e.frm ||
            charIsMoving !== e.mov || charIsRunning !== e.run || atTile !== e.at) begin
          failures++;
          $display("FAIL scoreboard t=%0t got x=%0d y=%0d tx=%0d ty=%0d dir=%0d frm=%0d mov=%0b run=%0b at=%0b, expected x=%0d y=%0d tx=%0d ty=%0d dir=%0d frm=%0d mov=%0b run=%0b at=%0b",
                   $time, charxcurrpos, charycurrpos, target_x, target_y, direction,
                   charMoveFrame, charIsMoving, charIsRunning, atTile,
                   e.x, e.y, e.tx, e.ty, e.dir, e.frm, e.mov, e.run, e.at);
        end
      end
    end
  end

  initial begin : stim
    bit done;
    logic [7:0] keys [6];
    logic [7:0] kc;
    bit me, rb, bl, ft, rst;
    keys[0] = 8'h1A; keys[1] = 8'h16; keys[2] = 8'h04;
    keys[3] = 8'h07; keys[4] = 8'h00; keys[5] = 8'h55;

    // Reset, including a frame_tick on the same edge.
    tick(1'b1, 1'b1, 8'h16, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    settle(8'h00);
    chk("reset_x", charxcurrpos, SX);
    chk("reset_y", charycurrpos, SY);
    chk("reset_attile", atTile, 1);

    // Walk down (already facing down): 1 entry tick + 16 walk ticks.
    step_n(17, 8'h16, 1'b0, 1'b0);
    settle(8'h00);
    chk("walk_down_y", charycurrpos, 240);
    chk("walk_down_dir", direction, 0);
    chk("walk_down_attile", atTile, 1);

    // Turn right, then step right.
    step_n(5, 8'h07, 1'b0, 1'b0);
    settle(8'h07);
    chk("turn_right_dir", direction, 3);
    chk("turn_right_x", charxcurrpos, 208);
    step_n(17, 8'h07, 1'b0, 1'b0);
    settle(8'h00);
    chk("walk_right_x", charxcurrpos, 224);

    // Turn down, then a step with run_btn held; keys released mid-step.
    step_n(5, 8'h16, 1'b0, 1'b0);
    step_n(5, 8'h16, 1'b1, 1'b0);
    settle(8'h00);
    chk("run_flag", charIsRunning, RUN_EN ? 1 : 0);
    chk("run_mid_y", charycurrpos, RUN_EN ? 248 : 244);
    step_n(4, 8'h00, 1'b0, 1'b0);
    settle(8'h00);
    chk("run_8tick_y", charycurrpos, RUN_EN ? 256 : 248);
    if (!RUN_EN) step_n(8, 8'h00, 1'b0, 1'b0);
    settle(8'h00);
    chk("step_done_y", charycurrpos, 256);

    // Blocked tile ahead: bump in place.
    step_n(6, 8'h16, 1'b0, 1'b1);
    settle(8'h16);
    chk("bump_moving", charIsMoving, 0);
    chk("bump_mid_y", charycurrpos, 256);
    step_n(11, 8'h16, 1'b0, 1'b1);
    settle(8'h00);
    chk("bump_y", charycurrpos, 256);
    chk("bump_attile", atTile, 1);

    // Walk left all the way to the map edge, then bump against it.
    step_n(5, 8'h04, 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick(1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0);
      if (m_x == 0 && m_mode == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL left_edge_bound: edge not reached within 400 ticks, expected reached");
    end
    settle(8'h04);
    chk("left_edge_x", charxcurrpos, 0);
    chk("left_edge_target", target_x, 0);
    step_n(9, 8'h04, 1'b0, 1'b0);
    settle(8'h04);
    chk("edge_bump_frame", charMoveFrame, 2);
    chk("edge_bump_x", charxcurrpos, 0);
    step_n(8, 8'h04, 1'b0, 1'b0);
    settle(8'h00);
    chk("edge_bump_end_x", charxcurrpos, 0);

    // Reset in the middle of a walk step (walk tick 7).
    step_n(5, 8'h07, 1'b0, 1'b0);
    step_n(8, 8'h07, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    settle(8'h00);
    chk("midstep_reset_x", charxcurrpos, SX);
    chk("midstep_reset_y", charycurrpos, SY);
    chk("midstep_reset_attile", atTile, 1);
    chk("midstep_reset_frame", charMoveFrame, 0);

    // Randomized traffic against the reference model.
    kc = 8'h16;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) kc = keys[$urandom_range(0, 5)];
      ft  = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      me  = ($urandom_range(0, 9) != 0);
      rb  = $urandom_range(0, 1) != 0;
      bl  = ($urandom_range(0, 4) == 0);
      tick(ft, rst, kc, me, rb, bl);
    end

    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
